// File: rtl/sys_ctrl_burst_pkg.sv
// Command opcodes and FSM state encoding shared by the system controller and its bench.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR    = 8'hAA;
  localparam logic [7:0] CMD_RF_RD    = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP   = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;
  localparam logic [7:0] CMD_BURST_WR = 8'hEE;
  localparam logic [7:0] CMD_BURST_RD = 8'hFF;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_ADDR = 4'd1,
    GET_CNT  = 4'd2,
    GET_DATA = 4'd3,
    RF_WR    = 4'd4,
    RF_RD    = 4'd5,
    RD_WAIT  = 4'd6,
    GET_A    = 4'd7,
    GET_B    = 4'd8,
    GET_FUN  = 4'd9,
    ALU_RUN  = 4'd10,
    ALU_WAIT = 4'd11,
    TX_PUSH  = 4'd12
  } state_e;

endpackage

// File: rtl/tx_byte_pusher.sv
// Serialises up to NBYTES loaded bytes (LS first) into the TX FIFO, one per cycle while not full.
// TX_DATA is stable while the FIFO is full; o_done fires with the last accepted byte.
module tx_byte_pusher #(
  parameter int D_WIDTH = 8,
  parameter int NBYTES  = 2,
  parameter int NB_W    = $clog2(NBYTES + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_load,
  input  logic [NBYTES*D_WIDTH-1:0] i_dat,
  input  logic [NB_W-1:0]           i_nbytes,
  input  logic                      i_full,
  output logic [D_WIDTH-1:0]        o_tx_dat,
  output logic                      o_tx_vld,
  output logic                      o_done
);

  logic [NBYTES*D_WIDTH-1:0] r_buf;
  logic [NB_W-1:0]           r_left;
  logic                      w_push;

  assign w_push   = (r_left != '0) && !i_full;
  assign o_tx_vld = w_push;
  assign o_tx_dat = r_buf[D_WIDTH-1:0];
  assign o_done   = w_push && (r_left == NB_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf  <= '0;
      r_left <= '0;
    end else if (i_load) begin
      r_buf  <= i_dat;
      r_left <= i_nbytes;
    end else if (w_push) begin
      r_buf  <= r_buf >> D_WIDTH;
      r_left <= r_left - NB_W'(1);
    end
  end

endmodule

// File: rtl/sys_ctrl_burst.sv
// Byte-framed command decoder driving RF/ALU transactions and queueing response bytes.
// Single and burst transfers share one path: single commands run as bursts of length one.
module sys_ctrl_burst
  import sys_ctrl_pkg::*;
#(
  parameter int D_WIDTH    = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int ALU_BYTES  = 2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [D_WIDTH-1:0]             RX_DATA,
  input  logic                           RX_VLD,
  input  logic                           FIFO_FULL,
  output logic [D_WIDTH-1:0]             TX_DATA,
  output logic                           TX_VLD,
  output logic [ADDR_WIDTH-1:0]          RF_Address,
  output logic                           RF_WrEn,
  output logic [D_WIDTH-1:0]             RF_WrData,
  output logic                           RF_RdEn,
  input  logic [D_WIDTH-1:0]             RF_RdData,
  input  logic                           RF_RdData_VLD,
  output logic                           ALU_EN,
  output logic [FUN_WIDTH-1:0]           ALU_FUN,
  input  logic [ALU_BYTES*D_WIDTH-1:0]   ALU_OUT,
  input  logic                           ALU_OUT_VLD,
  output logic                           CLKG_EN,
  output logic                           CLKDIV_EN,
  output logic                           CMD_ERR
);

  localparam int AW_BITS = ALU_BYTES * D_WIDTH;
  localparam int NB_W    = $clog2(ALU_BYTES + 1);

  state_e                r_state, w_next;
  logic [D_WIDTH-1:0]    r_cmd, r_cnt, r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [FUN_WIDTH-1:0]  r_fun;
  logic                  r_alu_en, r_clkg_tail, r_clkdiv_en;
  logic                  w_known, w_is_rd, w_is_burst, w_last, w_busy;
  logic                  w_load, w_push_done;
  logic [AW_BITS-1:0]    w_load_dat;
  logic [NB_W-1:0]       w_load_n;

  assign w_known = (RX_DATA == D_WIDTH'(CMD_RF_WR))    || (RX_DATA == D_WIDTH'(CMD_RF_RD))   ||
                   (RX_DATA == D_WIDTH'(CMD_ALU_OP))   || (RX_DATA == D_WIDTH'(CMD_ALU_NOP)) ||
                   (RX_DATA == D_WIDTH'(CMD_BURST_WR)) || (RX_DATA == D_WIDTH'(CMD_BURST_RD));
  assign w_is_rd    = (r_cmd == D_WIDTH'(CMD_RF_RD))    || (r_cmd == D_WIDTH'(CMD_BURST_RD));
  assign w_is_burst = (r_cmd == D_WIDTH'(CMD_BURST_WR)) || (r_cmd == D_WIDTH'(CMD_BURST_RD));
  assign w_last     = (r_cnt == D_WIDTH'(1));
  assign w_busy     = (r_state == RF_WR)   || (r_state == RF_RD)    || (r_state == RD_WAIT) ||
                      (r_state == ALU_RUN) || (r_state == ALU_WAIT) || (r_state == TX_PUSH);

  assign w_load     = ((r_state == RD_WAIT) && RF_RdData_VLD) || ((r_state == ALU_WAIT) && ALU_OUT_VLD);
  assign w_load_dat = (r_state == RD_WAIT) ? AW_BITS'(RF_RdData) : ALU_OUT;
  assign w_load_n   = (r_state == RD_WAIT) ? NB_W'(1) : NB_W'(ALU_BYTES);

  tx_byte_pusher #(.D_WIDTH(D_WIDTH), .NBYTES(ALU_BYTES), .NB_W(NB_W)) u_pusher (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_load   (w_load),
    .i_dat    (w_load_dat),
    .i_nbytes (w_load_n),
    .i_full   (FIFO_FULL),
    .o_tx_dat (TX_DATA),
    .o_tx_vld (TX_VLD),
    .o_done   (w_push_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (RX_VLD) begin
        if (RX_DATA == D_WIDTH'(CMD_ALU_OP))       w_next = GET_A;
        else if (RX_DATA == D_WIDTH'(CMD_ALU_NOP)) w_next = GET_FUN;
        else if (w_known)                          w_next = GET_ADDR;
      end
      GET_ADDR: if (RX_VLD) w_next = w_is_burst ? GET_CNT : (w_is_rd ? RF_RD : GET_DATA);
      GET_CNT:  if (RX_VLD) w_next = (RX_DATA == '0) ? IDLE : (w_is_rd ? RF_RD : GET_DATA);
      GET_DATA, GET_A, GET_B: if (RX_VLD) w_next = RF_WR;
      RF_WR: begin
        if (r_cmd == D_WIDTH'(CMD_ALU_OP)) w_next = w_last ? GET_FUN : GET_B;
        else                               w_next = w_last ? IDLE : GET_DATA;
      end
      RF_RD:    w_next = RD_WAIT;
      RD_WAIT:  if (RF_RdData_VLD) w_next = TX_PUSH;
      GET_FUN:  if (RX_VLD) w_next = ALU_RUN;
      ALU_RUN:  w_next = ALU_WAIT;
      ALU_WAIT: if (ALU_OUT_VLD) w_next = TX_PUSH;
      TX_PUSH:  if (w_push_done) w_next = (w_is_rd && !w_last) ? RF_RD : IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    RF_WrEn    = 1'b0;
    RF_RdEn    = 1'b0;
    RF_Address = '0;
    RF_WrData  = '0;
    ALU_FUN    = '0;
    CLKG_EN    = r_clkg_tail;
    ALU_EN     = r_alu_en;
    CLKDIV_EN  = r_clkdiv_en;
    CMD_ERR    = RX_VLD && (((r_state == IDLE) && !w_known) || w_busy);
    case (r_state)
      RF_WR: begin
        RF_WrEn    = 1'b1;
        RF_Address = r_addr;
        RF_WrData  = r_wdata;
      end
      RF_RD: begin
        RF_RdEn    = 1'b1;
        RF_Address = r_addr;
      end
      ALU_RUN, ALU_WAIT: begin
        ALU_FUN = r_fun;
        CLKG_EN = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_cnt       <= '0;
      r_wdata     <= '0;
      r_addr      <= '0;
      r_fun       <= '0;
      r_alu_en    <= 1'b0;
      r_clkg_tail <= 1'b0;
      r_clkdiv_en <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_alu_en    <= (r_state == ALU_RUN);
      r_clkg_tail <= (r_state == ALU_WAIT) && ALU_OUT_VLD;
      r_clkdiv_en <= 1'b1;
      case (r_state)
        IDLE: if (RX_VLD) begin
          // ALU operands go to RF[0] then RF[1], as a two-word write run
          r_cmd  <= RX_DATA;
          r_cnt  <= (RX_DATA == D_WIDTH'(CMD_ALU_OP)) ? D_WIDTH'(2) : D_WIDTH'(1);
          r_addr <= '0;
        end
        GET_ADDR: if (RX_VLD) r_addr <= RX_DATA[ADDR_WIDTH-1:0];
        GET_CNT:  if (RX_VLD) r_cnt <= RX_DATA;
        GET_DATA, GET_A, GET_B: if (RX_VLD) r_wdata <= RX_DATA;
        GET_FUN:  if (RX_VLD) r_fun <= RX_DATA[FUN_WIDTH-1:0];
        RF_WR: begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
          r_cnt  <= r_cnt - D_WIDTH'(1);
        end
        TX_PUSH: if (w_push_done) begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
          r_cnt  <= r_cnt - D_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Directed bench for sys_ctrl_burst with a behavioural RF and a fixed-latency ALU responder.
module tb_sys_ctrl_burst;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 4;
  localparam int AB = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [DW-1:0]   RX_DATA = '0;
  logic            RX_VLD = 1'b0;
  logic            FIFO_FULL = 1'b0;
  logic [DW-1:0]   TX_DATA;
  logic            TX_VLD;
  logic [AW-1:0]   RF_Address;
  logic            RF_WrEn;
  logic [DW-1:0]   RF_WrData;
  logic            RF_RdEn;
  logic [DW-1:0]   RF_RdData;
  logic            RF_RdData_VLD;
  logic            ALU_EN;
  logic [FW-1:0]   ALU_FUN;
  logic [AB*DW-1:0] ALU_OUT;
  logic            ALU_OUT_VLD;
  logic            CLKG_EN;
  logic            CLKDIV_EN;
  logic            CMD_ERR;

  logic [AB*DW-1:0] alu_result = '0;
  logic [1:0]       alu_pipe;
  logic [DW-1:0]    mem [16];

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, err_cnt = 0, tx_while_full = 0;
  logic [DW-1:0] last_wr_data = '0;
  logic [AW-1:0] last_wr_addr = '0;
  logic [FW-1:0] last_fun = '0;
  logic [DW-1:0] tx_q [$];

  sys_ctrl_burst #(.D_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW), .ALU_BYTES(AB)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VLD(RX_VLD), .FIFO_FULL(FIFO_FULL),
    .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .RF_Address(RF_Address), .RF_WrEn(RF_WrEn),
    .RF_WrData(RF_WrData), .RF_RdEn(RF_RdEn), .RF_RdData(RF_RdData),
    .RF_RdData_VLD(RF_RdData_VLD), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD), .CLKG_EN(CLKG_EN), .CLKDIV_EN(CLKDIV_EN), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // Register file: read data returns one cycle after RF_RdEn.
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hA0 + 8'(i);
      RF_RdData     <= '0;
      RF_RdData_VLD <= 1'b0;
    end else begin
      if (RF_WrEn) mem[RF_Address] <= RF_WrData;
      RF_RdData_VLD <= RF_RdEn;
      if (RF_RdEn) RF_RdData <= mem[RF_Address];
    end
  end

  // ALU: result valid two cycles after ALU_EN.
  always @(posedge CLK) begin
    if (RST) alu_pipe <= '0;
    else     alu_pipe <= {alu_pipe[0], ALU_EN};
  end
  assign ALU_OUT_VLD = alu_pipe[1];
  assign ALU_OUT     = alu_result;

  always @(negedge CLK) begin
    if (!RST) begin
      if (TX_VLD) begin
        tx_q.push_back(TX_DATA);
        if (FIFO_FULL) tx_while_full++;
      end
      if (RF_WrEn) begin
        wr_cnt++;
        last_wr_addr = RF_Address;
        last_wr_data = RF_WrData;
      end
      if (RF_RdEn) rd_cnt++;
      if (ALU_EN) begin
        alu_cnt++;
        last_fun = ALU_FUN;
      end
      if (CMD_ERR) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_DATA = b;
    RX_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_VLD  = 1'b0;
  endtask

  int wr0, rd0, alu0, err0;

  initial begin
    // Reset state
    cyc(3);
    check("reset_outputs",
          32'({TX_DATA, TX_VLD, RF_Address, RF_WrEn, RF_WrData, RF_RdEn, ALU_EN, ALU_FUN,
               CLKG_EN, CLKDIV_EN, CMD_ERR}), 32'h0);
    RST = 1'b0;
    cyc(1);
    check("clkdiv_after_reset", 32'(CLKDIV_EN), 32'h1);

    // 1: single write then read-back
    send(8'hAA); send(8'h05); send(8'h3C);
    check("wr_strobe", 32'(RF_WrEn), 32'h1);
    check("wr_addr", 32'(RF_Address), 32'h5);
    check("wr_data", 32'(RF_WrData), 32'h3C);
    cyc(1);
    check("wr_strobe_one_cycle", 32'(RF_WrEn), 32'h0);
    check("wr_count", 32'(wr_cnt), 32'd1);
    tx_q.delete();
    send(8'hBB); send(8'h05);
    cyc(8);
    check("rd_tx_count", 32'(tx_q.size()), 32'd1);
    if (tx_q.size() >= 1) check("rd_tx_byte", 32'(tx_q[0]), 32'h3C);

    // 2: ALU with operands, ADD
    tx_q.delete();
    alu_result = 16'h000A;
    alu0 = alu_cnt;
    send(8'hCC); send(8'h07); send(8'h03); send(8'h00);
    check("alu_clkg_rise", 32'({CLKG_EN, ALU_EN}), 32'b10);
    cyc(1);
    check("alu_en_pulse", 32'({CLKG_EN, ALU_EN, ALU_FUN}), 32'({1'b1, 1'b1, 4'h0}));
    cyc(8);
    check("alu_rf0", 32'(mem[0]), 32'h07);
    check("alu_rf1", 32'(mem[1]), 32'h03);
    check("alu_en_count", 32'(alu_cnt - alu0), 32'd1);
    check("alu_tx_count", 32'(tx_q.size()), 32'd2);
    if (tx_q.size() >= 2) check("alu_tx_bytes", 32'({tx_q[0], tx_q[1]}), 32'h0A00);
    check("clkg_released", 32'(CLKG_EN), 32'h0);

    // ALU without operands, FUN=5
    tx_q.delete();
    alu_result = 16'h1234;
    send(8'hDD); send(8'h05);
    cyc(10);
    check("alu2_fun", 32'(last_fun), 32'h5);
    check("alu2_tx_count", 32'(tx_q.size()), 32'd2);
    if (tx_q.size() >= 2) check("alu2_tx_bytes", 32'({tx_q[0], tx_q[1]}), 32'h3412);

    // 3: burst write with address wrap, then burst read
    wr0 = wr_cnt;
    send(8'hEE); send(8'h0E); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
    cyc(4);
    check("bw_count", 32'(wr_cnt - wr0), 32'd3);
    check("bw_rf", 32'({mem[14], mem[15], mem[0]}), 32'h112233);
    tx_q.delete();
    rd0 = rd_cnt;
    send(8'hFF); send(8'h0E); send(8'h03);
    cyc(20);
    check("br_rd_count", 32'(rd_cnt - rd0), 32'd3);
    check("br_tx_count", 32'(tx_q.size()), 32'd3);
    if (tx_q.size() >= 3) check("br_tx_bytes", 32'({tx_q[0], tx_q[1], tx_q[2]}), 32'h112233);

    // 4: read under FIFO_FULL backpressure, plus a byte arriving while busy
    tx_q.delete();
    tx_while_full = 0;
    FIFO_FULL = 1'b1;
    send(8'hBB); send(8'h02);
    cyc(16);
    err0 = err_cnt;
    send(8'hAA);
    check("busy_cmd_err", 32'(err_cnt - err0), 32'd1);
    check("full_hold", 32'({TX_VLD, TX_DATA}), 32'({1'b0, 8'hA2}));
    FIFO_FULL = 1'b0;
    #1;
    check("full_release_push", 32'({TX_VLD, TX_DATA}), 32'({1'b1, 8'hA2}));
    cyc(1);
    check("push_once", 32'(TX_VLD), 32'h0);
    check("full_tx_count", 32'(tx_q.size()), 32'd1);
    check("tx_while_full", 32'(tx_while_full), 32'd0);

    // 5: unknown command, zero-length burst, then a normal read
    wr0 = wr_cnt; rd0 = rd_cnt; alu0 = alu_cnt; err0 = err_cnt;
    send(8'h55);
    check("unknown_err", 32'(err_cnt - err0), 32'd1);
    send(8'hEE); send(8'h00); send(8'h00);
    cyc(3);
    check("zero_burst_strobes", 32'({wr_cnt - wr0, rd_cnt - rd0, alu_cnt - alu0}), 32'h0);
    check("zero_burst_no_err", 32'(err_cnt - err0), 32'd1);
    tx_q.delete();
    send(8'hBB); send(8'h03);
    cyc(8);
    check("idle_after_zero", 32'(tx_q.size()), 32'd1);
    if (tx_q.size() >= 1) check("idle_after_zero_byte", 32'(tx_q[0]), 32'hA3);

    // 6: reset mid-frame
    send(8'hAA); send(8'h05);
    RST = 1'b1;
    cyc(1);
    check("midframe_reset",
          32'({TX_DATA, TX_VLD, RF_Address, RF_WrEn, RF_WrData, RF_RdEn, ALU_EN, ALU_FUN,
               CLKG_EN, CLKDIV_EN, CMD_ERR}), 32'h0);
    RST = 1'b0;
    wr0 = wr_cnt; err0 = err_cnt;
    send(8'h3C);
    cyc(3);
    check("after_reset_err", 32'(err_cnt - err0), 32'd1);
    check("after_reset_no_wr", 32'(wr_cnt - wr0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
